// File: rtl/pipe_rr_arb.sv
// pipe_rr_arb: 4-way round-robin packet arbiter with a registered output stage
module pipe_rr_arb #(
    parameter int DATA_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [3:0]          in_last,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_id,
    output logic                out_last,
    input  logic                out_ready,
    output logic                busy
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t              r_state, w_state_nxt;
    logic [1:0]          r_ptr, r_lock_id;
    logic                r_out_valid, r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_out_id;
    logic                w_stage_ready, w_grant_vld, w_xfer, w_last;
    logic [1:0]          w_grant, w_cand;
    logic [DATA_W-1:0]   w_data;
    assign w_stage_ready = out_ready | ~r_out_valid;
    // grant: held by the packet owner in LOCK, else first valid requester from ptr
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = r_ptr;
        w_cand      = r_ptr;
        if (r_state == LOCK) begin
            w_grant_vld = 1'b1;
            w_grant     = r_lock_id;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                w_cand = r_ptr + 2'(k);
                if (in_valid[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_cand;
                end
            end
        end
    end
    assign in_ready  = (w_grant_vld & w_stage_ready & ~clr & ~rst) ? (4'(1) << w_grant) : 4'b0;
    assign w_xfer    = |(in_valid & in_ready);
    assign w_last    = in_last[w_grant];
    assign w_data    = in_data[int'(w_grant)*DATA_W +: DATA_W];
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;
    assign busy      = r_out_valid | (r_state == LOCK);
    // next state: a non-last beat locks the grant, a last beat releases it
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) w_state_nxt = w_last ? IDLE : LOCK;
    end
    // state, pointer and lock owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_lock_id <= 2'd0;
        end else if (clr) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_lock_id <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer && w_last) r_ptr <= w_grant + 2'd1;
            if (w_xfer && !w_last) r_lock_id <= w_grant;
        end
    end
    // output stage: load on transfer, drain when downstream accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_id    <= w_grant;
            r_out_last  <= w_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/pipe_rr_arb.md
PIPE_RR_ARB -- requirements
Module: pipe_rr_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 256, giving the payload width of every requester and of the output.
REQ-002 SHALL have a fixed requester count of 4, with requester index width 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1: synchronous flush of all state.
REQ-006 SHALL have port in_valid, input, 4: per-requester valid.
REQ-007 SHALL have port in_data, input, 4*DATA_W: requester i payload in bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_last, input, 4: per-requester end-of-packet flag.
REQ-009 SHALL have port in_ready, output, 4: per-requester ready, one-hot or zero.
REQ-010 SHALL have port out_valid, output, 1: output stage holds a beat.
REQ-011 SHALL have port out_data, output, DATA_W: registered payload.
REQ-012 SHALL have port out_id, output, 2: index of the source requester.
REQ-013 SHALL have port out_last, output, 1: registered end-of-packet flag.
REQ-014 SHALL have port out_ready, input, 1: downstream ready.
REQ-015 SHALL have port busy, output, 1: out_valid OR state==LOCK.

Function
REQ-016 SHALL define stage_ready = out_ready | ~out_valid (combinational).
REQ-017 SHALL keep a 2-bit round-robin pointer ptr and a state machine with states IDLE and LOCK, plus a 2-bit lock_id.
REQ-018 In IDLE, grant SHALL be the first index with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); there is no grant if none is valid.
REQ-019 In LOCK, grant SHALL be lock_id, regardless of the other valids.
REQ-020 in_ready[i] SHALL be stage_ready & ~clr & (grant==i); all other bits SHALL be 0.
REQ-021 A transfer SHALL occur when in_valid[g] & in_ready[g]. On a transfer, out_data, out_id and out_last SHALL load g's payload, g and in_last[g], and out_valid SHALL become 1.
REQ-022 Without a transfer, out_valid SHALL clear when out_ready=1 and SHALL otherwise hold; out_data, out_id and out_last SHALL hold.
REQ-023 Latency SHALL be 1 cycle from input transfer to out_valid. Full throughput SHALL hold: one beat per cycle while out_ready stays high.
REQ-024 IDLE -> LOCK SHALL occur on a transfer with in_last=0, setting lock_id=g.
REQ-025 On a transfer with in_last=1 in IDLE, the state SHALL stay IDLE (single-beat packet).
REQ-026 LOCK -> IDLE SHALL occur on a transfer with in_last=1. In LOCK, other requesters SHALL stay blocked until then.
REQ-027 ptr SHALL update to g+1 (mod 4, wrapping 3->0) only on a transfer with in_last=1, and SHALL hold otherwise.
REQ-028 A transfer and a downstream accept in the same cycle SHALL keep out_valid=1 with the new beat, with no bubble.
REQ-029 A requester dropping in_valid mid-packet in LOCK SHALL leave the state LOCK and produce no transfer; the arbiter SHALL wait.
REQ-030 clr SHALL have priority over all updates: out_valid=0, out_data=0, out_id=0, out_last=0, state=IDLE, ptr=0, lock_id=0, and no transfer that cycle.

Reset
REQ-031 While rst=1 (asynchronous), outputs SHALL be: out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, in_ready=0; internally state=IDLE, ptr=0, lock_id=0.
REQ-032 After rst deasserts, in_ready SHALL follow REQ-020, with the first grant searched from index 0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet, with no residual lock.

Verification
REQ-034 Requesters 0-3 all valid, single-beat, out_ready=1 -> out_id sequence 0,1,2,3,0, one beat per cycle.
REQ-035 Requester 1 sends 3 beats (last on the 3rd) while requester 2 is valid throughout -> out_id = 1,1,1,2; in_ready[2]=0 during LOCK.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_id stable; in_ready=0 throughout; resume with no loss or duplication.
REQ-037 clr asserted in LOCK with out_valid=1 -> next cycle out_valid=0, busy=0, grant restarts from index 0.
REQ-038 Requester 0 drops in_valid after beat 1 of 2 -> no transfer from others; the packet completes when in_valid[0] returns with last.
REQ-039 rst pulsed mid-cycle during streaming -> outputs zero immediately, without waiting for clk.
